sdram_ctrl: RTL

SDRAM_CTRL -- requirements
Module: sdram_ctrl

---
 rtl/sdram_pkg.sv | 37 +++
 rtl/sdram_refresh_timer.sv | 41 ++++
 rtl/sdram_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, controller state enum and mode register helper.
package sdram_pkg;

    typedef logic [2:0] cmd_t;

    // Command bits are {ras_n, cas_n, we_n}
    localparam cmd_t CmdNop = 3'b111;
    localparam cmd_t CmdAct = 3'b011;
    localparam cmd_t CmdRd  = 3'b101;
    localparam cmd_t CmdWr  = 3'b100;
    localparam cmd_t CmdPre = 3'b010;
    localparam cmd_t CmdRef = 3'b001;
    localparam cmd_t CmdLmr = 3'b000;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitRef1,
        StInitRef2,
        StInitLmr,
        StIdle,
        StAct,
        StRw,
        StDelay,
        StRef
    } state_e;

    // Burst length 1, sequential, CAS latency cl, single-location writes (A9=1)
    function automatic logic [10:0] mode_reg(input int unsigned cl);
        logic [10:0] m;
        m      = '0;
        m[9]   = 1'b1;
        m[6:4] = 3'(cl);
        return m;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer; raises pending on each wrap until the controller clears it.
module sdram_refresh_timer #(
    parameter int unsigned T_REFI = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int unsigned CntW = $clog2(T_REFI);

    logic [CntW-1:0] r_cnt;
    logic            r_pending;
    logic            w_wrap;

    assign w_wrap = enable && (r_cnt == CntW'(T_REFI - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else if (enable) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A wrap wins over a clear so no interval is ever lost
            if (w_wrap) begin
                r_pending <= 1'b1;
            end else if (clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/sdram_ctrl.sv
// Single-word SDRAM controller with power-up init, auto-refresh and auto-precharge accesses.
// Define SDRAM_CTRL_FAST_INIT_EN to shorten the power-up NOP wait to 16 cycles for simulation.
module sdram_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned CWIDTH = 8,
    parameter int unsigned T_INIT = 20000,
    parameter int unsigned T_RP   = 2,
    parameter int unsigned T_RCD  = 2,
    parameter int unsigned T_RC   = 6,
    parameter int unsigned CL     = 2,
    parameter int unsigned T_REFI = 780
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     req_we,
    input  logic [AWIDTH+CWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0]        req_wdata,
    output logic                     req_ack,
    output logic                     rd_valid,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     sd_ras_n,
    output logic                     sd_cas_n,
    output logic                     sd_we_n,
    output logic [AWIDTH-1:0]        sd_addr,
    output logic [DWIDTH-1:0]        sd_data_o,
    output logic                     sd_data_oe,
    input  logic [DWIDTH-1:0]        sd_data_i
);

`ifdef SDRAM_CTRL_FAST_INIT_EN
    localparam int unsigned InitCyc = 16;
`else
    localparam int unsigned InitCyc = T_INIT;
`endif
    // Long enough for tRC and for the auto-precharge to finish after read data returns
    localparam int unsigned PostCyc =
        (T_RC > T_RCD + CL + T_RP) ? (T_RC - T_RCD) : (CL + T_RP);

    state_e            r_state;
    logic [15:0]       r_cnt;
    logic              r_init_done;
    cmd_t              r_cmd;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_oe;
    logic              r_ack;
    logic [CL:0]       r_rd_pipe;
    logic              r_rd_valid;
    logic [DWIDTH-1:0] r_rd_data;

    logic              w_pending;
    logic              w_ref_clear;
    logic [AWIDTH-1:0] w_row;
    logic [AWIDTH-1:0] w_col_addr;
    logic [AWIDTH-1:0] w_pre_addr;
    logic [AWIDTH-1:0] w_mode_addr;

    assign w_row       = req_addr[AWIDTH+CWIDTH-1:CWIDTH];
    assign w_ref_clear = (r_state == StIdle) && w_pending;

    always_comb begin
        w_col_addr                = '0;
        w_col_addr[CWIDTH-1:0]    = req_addr[CWIDTH-1:0];
        w_col_addr[10]            = 1'b1;
        w_pre_addr                = '0;
        w_pre_addr[10]            = 1'b1;
        w_mode_addr               = '0;
        w_mode_addr[10:0]         = mode_reg(CL);
    end

    sdram_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (r_init_done),
        .clear   (w_ref_clear),
        .pending (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StInitWait;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_cmd       <= CmdNop;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_oe        <= 1'b0;
            r_ack       <= 1'b0;
            r_rd_pipe   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_cmd      <= CmdNop;
            r_ack      <= 1'b0;
            r_oe       <= 1'b0;
            r_cnt      <= r_cnt + 16'd1;
            r_rd_pipe  <= {r_rd_pipe[CL-1:0], 1'b0};
            r_rd_valid <= r_rd_pipe[CL];
            if (r_rd_pipe[CL]) begin
                r_rd_data <= sd_data_i;
            end

            case (r_state)
                StInitWait: if (r_cnt == 16'(InitCyc - 1)) begin
                    r_cnt   <= '0;
                    r_cmd   <= CmdPre;
                    r_addr  <= w_pre_addr;
                    r_state <= StInitPre;
                end
                StInitPre: if (r_cnt == 16'(T_RP - 1)) begin
                    r_cnt   <= '0;
                    r_cmd   <= CmdRef;
                    r_state <= StInitRef1;
                end
                StInitRef1: if (r_cnt == 16'(T_RC - 1)) begin
                    r_cnt   <= '0;
                    r_cmd   <= CmdRef;
                    r_state <= StInitRef2;
                end
                StInitRef2: if (r_cnt == 16'(T_RC - 1)) begin
                    r_cnt   <= '0;
                    r_cmd   <= CmdLmr;
                    r_addr  <= w_mode_addr;
                    r_state <= StInitLmr;
                end
                StInitLmr: if (r_cnt == 16'd2) begin
                    r_cnt       <= '0;
                    r_init_done <= 1'b1;
                    r_state     <= StIdle;
                end
                StIdle: begin
                    r_cnt <= '0;
                    if (w_pending) begin
                        r_cmd   <= CmdRef;
                        r_state <= StRef;
                    end else if (req) begin
                        r_cmd   <= CmdAct;
                        r_addr  <= w_row;
                        r_state <= StAct;
                    end
                end
                StAct: if (r_cnt == 16'(T_RCD - 1)) begin
                    r_cnt   <= '0;
                    r_addr  <= w_col_addr;
                    r_ack   <= 1'b1;
                    r_state <= StRw;
                    if (req_we) begin
                        r_cmd   <= CmdWr;
                        r_wdata <= req_wdata;
                        r_oe    <= 1'b1;
                    end else begin
                        r_cmd        <= CmdRd;
                        r_rd_pipe[0] <= 1'b1;
                    end
                end
                StRw: begin
                    r_cnt   <= '0;
                    r_state <= StDelay;
                end
                StDelay: if (r_cnt == 16'(PostCyc - 1)) begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
                // The IDLE cycle completes the REF-to-next-command spacing of T_RC
                StRef: if (r_cnt == 16'(T_RC - 2)) begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StInitWait;
                end
            endcase
        end
    end

    assign {sd_ras_n, sd_cas_n, sd_we_n} = r_cmd;
    assign sd_addr    = r_addr;
    assign sd_data_o  = r_wdata;
    assign sd_data_oe = r_oe;
    assign req_ack    = r_ack;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;

endmodule
